iter_mul_unit: RTL and testbench

Parametrised, multi-cycle shift-add multiplier execution unit for the MiniAlu-class datapath. It replaces the fixed single-cycle MUL/SMUL/LMUL paths with one iterative engine of configurable operand width and a per-operation signed/unsigned mode. The engine returns a full double-width product split into low and high words, suitable for a two-port RAM write. The controller talks to it through a start/busy/done handshake and stalls the IP while the unit is busy.

---
 rtl/iter_mul_unit.sv | 89 ++++++++
 tb/tb_iter_mul_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iter_mul_unit.sv
// Iterative shift-add multiplier, signed/unsigned, full 2*WIDTH product.
// Optional macro ITER_MUL_EARLY_TERM_EN: leave RUN once the multiplier runs out of set bits.
module iter_mul_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iData_A,
  input  logic [WIDTH-1:0] iData_B,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLow,
  output logic [WIDTH-1:0] oResultHigh
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplr, mplr_shr;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               start_ok, last_run;

  // Magnitudes are unsigned WIDTH-bit, so |-2^(W-1)| = 2^(W-1) fits exactly.
  assign mag_a    = (iSigned && iData_A[WIDTH-1]) ? WIDTH'(-iData_A) : iData_A;
  assign mag_b    = (iSigned && iData_B[WIDTH-1]) ? WIDTH'(-iData_B) : iData_B;
  assign start_ok = iStart && (state == IDLE || state == DONE);
  assign mplr_shr = mplr >> 1;

`ifdef ITER_MUL_EARLY_TERM_EN
  assign last_run = (cnt == CNT_W'(WIDTH - 1)) || (mplr_shr == '0);
`else
  assign last_run = (cnt == CNT_W'(WIDTH - 1));
`endif

  assign oBusy = (state == RUN) || (state == FIX);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (last_run) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = iStart ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand       <= '0;
      acc         <= '0;
      mplr        <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      oDone       <= 1'b0;
      oResultLow  <= '0;
      oResultHigh <= '0;
    end else begin
      oDone <= 1'b0;
      if (start_ok) begin
        mcand <= {{WIDTH{1'b0}}, mag_a};
        mplr  <= mag_b;
        acc   <= '0;
        cnt   <= '0;
        neg   <= iSigned & (iData_A[WIDTH-1] ^ iData_B[WIDTH-1]);
      end else if (state == RUN) begin
        if (mplr[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mplr  <= mplr_shr;
        cnt   <= cnt + 1'b1;
      end else if (state == FIX) begin
        {oResultHigh, oResultLow} <= neg ? -acc : acc;
        oDone <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Self-checking bench for iter_mul_unit: directed table, handshake corner sequences, random vs. arithmetic model.
module tb_iter_mul_unit;
  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset, iStart, iSigned;
  logic [W-1:0] iData_A, iData_B;
  logic         oBusy, oDone;
  logic [W-1:0] oResultLow, oResultHigh;

  iter_mul_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSigned(iSigned),
    .iData_A(iData_A), .iData_B(iData_B), .oBusy(oBusy), .oDone(oDone),
    .oResultLow(oResultLow), .oResultHigh(oResultHigh)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         s;
    logic [W-1:0] a, b, lo, hi;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Exact product from plain integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Edges after the start edge until oDone is visible.
  function automatic int exp_lat(input logic s, input logic [W-1:0] b);
    int m, runs;
    m = (s && b[W-1]) ? (1 << W) - int'(b) : int'(b);
    runs = 1;
    for (int i = 0; i <= W; i++) if ((m >> i) != 0) runs = i + 1;
`ifdef ITER_MUL_EARLY_TERM_EN
    return runs + 1;
`else
    return (runs > 0) ? W + 1 : W + 1;
`endif
  endfunction

  // Called just after the start edge; returns in the DONE cycle.
  task automatic wait_done(output int lat, output logic hs_ok);
    lat = 0;
    hs_ok = 1'b1;
    while (!oDone && lat < 100) begin
      if (!oBusy) hs_ok = 1'b0;
      @(posedge Clock); #1;
      lat++;
    end
    if (oBusy) hs_ok = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] lo, output logic [W-1:0] hi,
                        output int lat, output logic hs_ok);
    @(negedge Clock);
    iStart = 1'b1; iSigned = s; iData_A = a; iData_B = b;
    @(posedge Clock); #1;
    iStart = 1'b0; iData_A = W'($urandom); iData_B = W'($urandom); iSigned = ~s;
    wait_done(lat, hs_ok);
    lo = oResultLow;
    hi = oResultHigh;
    @(posedge Clock); #1;
    if (oDone) hs_ok = 1'b0;
  endtask

  vec_t         tbl[10];
  logic [W-1:0] lo, hi;
  int           lat;
  logic         hs_ok, seen_done;

  initial begin
    tbl[0] = '{1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000};
    tbl[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE};
    tbl[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
    tbl[3] = '{1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF};
    tbl[4] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000};
    tbl[5] = '{1'b0, 16'hFFFD, 16'h0007, 16'hFFEB, 16'h0006};
    tbl[6] = '{1'b0, 16'h0003, 16'h0001, 16'h0003, 16'h0000};
    tbl[7] = '{1'b0, 16'h1234, 16'h0100, 16'h3400, 16'h0012};
    tbl[8] = '{1'b0, 16'hABCD, 16'h0000, 16'h0000, 16'h0000};
    tbl[9] = '{1'b1, 16'h7FFF, 16'h8000, 16'h8000, 16'hC000};

    Reset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iData_A = '0; iData_B = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_busy", oBusy, 0);
    chk("reset_done", oDone, 0);
    chk("reset_lo", oResultLow, 0);
    chk("reset_hi", oResultHigh, 0);
    @(negedge Clock); Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, lo, hi, lat, hs_ok);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lat", i), lat, exp_lat(tbl[i].s, tbl[i].b));
      chk($sformatf("tbl%0d_handshake", i), hs_ok, 1);
    end

    // Start during RUN is ignored; start in DONE begins back-to-back.
    @(negedge Clock);
    iStart = 1'b1; iSigned = 1'b0; iData_A = 16'h0003; iData_B = 16'h8005;
    @(posedge Clock); #1; iStart = 1'b0;
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    iStart = 1'b1; iData_A = 16'h0009; iData_B = 16'h0009;
    @(posedge Clock); #1; iStart = 1'b0;
    chk("ignore_busy", oBusy, 1);
    wait_done(lat, hs_ok);
    chk("ignore_lo", oResultLow, 16'h800F);
    chk("ignore_hi", oResultHigh, 16'h0001);
    chk("ignore_handshake", hs_ok, 1);
    iStart = 1'b1; iData_A = 16'h0002; iData_B = 16'h0004;
    @(posedge Clock); #1; iStart = 1'b0;
    chk("b2b_busy", oBusy, 1);
    chk("b2b_held_lo", oResultLow, 16'h800F);
    wait_done(lat, hs_ok);
    chk("b2b_lo", oResultLow, 16'h0008);
    chk("b2b_hi", oResultHigh, 16'h0000);
    chk("b2b_lat", lat, exp_lat(1'b0, 16'h0004));
    @(posedge Clock); #1;

    // Reset mid-operation discards it.
    @(negedge Clock);
    iStart = 1'b1; iSigned = 1'b0; iData_A = 16'h1234; iData_B = 16'h5678;
    @(posedge Clock); #1; iStart = 1'b0;
    repeat (7) @(posedge Clock);
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    chk("midrst_busy", oBusy, 0);
    chk("midrst_done", oDone, 0);
    chk("midrst_lo", oResultLow, 0);
    chk("midrst_hi", oResultHigh, 0);
    @(negedge Clock); Reset = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (oDone || oBusy) seen_done = 1'b1;
    end
    chk("midrst_no_done", seen_done, 0);
    run_op(1'b0, 16'h1234, 16'h5678, lo, hi, lat, hs_ok);
    chk("post_rst_prod", {hi, lo}, model(1'b0, 16'h1234, 16'h5678));
    chk("post_rst_lat", lat, exp_lat(1'b0, 16'h5678));

    for (int i = 0; i < 40; i++) begin
      logic         s;
      logic [W-1:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      if (i % 8 == 0) a = 16'h8000;
      if (i % 8 == 1) b = 16'h8000;
      if (i % 8 == 2) b = W'($urandom_range(0, 15));
      run_op(s, a, b, lo, hi, lat, hs_ok);
      chk($sformatf("rnd%0d_prod s=%0d a=%h b=%h", i, s, a, b), {hi, lo}, model(s, a, b));
      chk($sformatf("rnd%0d_lat", i), lat, exp_lat(s, b));
      chk($sformatf("rnd%0d_handshake", i), hs_ok, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
